// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolver (prediction queue entries and
// predictor update records).
package bp_pkg;

  localparam int PC_W    = 32;
  localparam int IDX_W   = 8;
  localparam int IDX_LSB = 2;
  localparam int DEPTH   = 4;

  // Not-taken branches resume after the branch and its delay slot.
  localparam logic [PC_W-1:0] DELAY_SLOT_OFFSET = PC_W'(8);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic [PC_W-1:0] target;
  } bp_entry_t;

  typedef struct packed {
    logic             branch;
    logic             res;
    logic             fail;
    logic [IDX_W-1:0] addr;
    logic [IDX_W-1:0] target;
  } bp_update_t;

  function automatic logic entry_mispredict(bp_entry_t e, logic act_taken,
                                            logic [PC_W-1:0] act_target);
    return (act_taken != e.taken) || (act_taken && e.taken && (act_target != e.target));
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Prediction / resolution / predictor-update bundle of the branch resolver.
// Optional BRANCH_RESOLVER_PERF_EN adds the performance counter outputs.
interface branch_resolver_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             pred_valid;
  logic             pred_ready;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             flush;
  logic             upd_branch;
  logic             upd_res;
  logic             upd_fail;
  logic [IDX_W-1:0] upd_addr;
  logic [IDX_W-1:0] upd_target;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [OCC_W-1:0] occupancy;
`ifdef BRANCH_RESOLVER_PERF_EN
  logic [31:0]      perf_branch_cnt;
  logic [31:0]      perf_miss_cnt;

  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target, flush,
    input  pred_ready, upd_branch, upd_res, upd_fail, upd_addr, upd_target,
    input  redirect_valid, redirect_pc, occupancy, perf_branch_cnt, perf_miss_cnt
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target, flush,
    output pred_ready, upd_branch, upd_res, upd_fail, upd_addr, upd_target,
    output redirect_valid, redirect_pc, occupancy, perf_branch_cnt, perf_miss_cnt
  );
`else
  modport master (
    output pred_valid, pred_pc, pred_taken, pred_target,
    output res_valid, res_taken, res_target, flush,
    input  pred_ready, upd_branch, upd_res, upd_fail, upd_addr, upd_target,
    input  redirect_valid, redirect_pc, occupancy
  );
  modport slave (
    input  pred_valid, pred_pc, pred_taken, pred_target,
    input  res_valid, res_taken, res_target, flush,
    output pred_ready, upd_branch, upd_res, upd_fail, upd_addr, upd_target,
    output redirect_valid, redirect_pc, occupancy
  );
`endif

endinterface

// File: rtl/bp_fifo.sv
// Generic circular FIFO with push/pop/clear; head is read combinationally from
// the storage array. A pop frees a slot for a same-cycle push even when full.
module bp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop & ~empty & ~clear;
    do_push  = push & ~clear & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clear) begin
      // Drop everything by catching the read pointer up to the write pointer.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Queues fetch-time branch predictions and checks them against execute results,
// producing predictor updates and a fetch redirect on mispredict.
// Optional BRANCH_RESOLVER_PERF_EN adds branch/miss performance counters.
module branch_resolver #(
  parameter int DEPTH   = bp_pkg::DEPTH,
  parameter int PC_W    = bp_pkg::PC_W,
  parameter int IDX_W   = bp_pkg::IDX_W,
  parameter int IDX_LSB = bp_pkg::IDX_LSB
) (
  input  logic               clk,
  input  logic               rst,
  branch_resolver_if.slave   bus
);
  import bp_pkg::*;

  localparam int OCC_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = $bits(bp_entry_t);

  bp_entry_t          push_entry;
  bp_entry_t          head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [OCC_W-1:0]   count;
  logic               full, empty;
  logic               resolve, fail, clear;

  bp_update_t         upd_q, upd_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  assign push_entry = '{pc: bus.pred_pc, taken: bus.pred_taken, target: bus.pred_target};
  assign head_entry = bp_entry_t'(head_bits);

  bp_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.pred_valid),
    .pop   (resolve),
    .clear (clear),
    .din   (push_entry),
    .head  (head_bits),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    resolve          = bus.res_valid & ~empty & ~bus.flush;
    fail             = resolve & entry_mispredict(head_entry, bus.res_taken, bus.res_target);
    // A mispredict squashes the younger wrong-path entries along with the head.
    clear            = bus.flush | fail;

    upd_d            = '0;
    redirect_valid_d = fail;
    redirect_pc_d    = redirect_pc_q;
    if (resolve) begin
      upd_d.branch = 1'b1;
      upd_d.res    = bus.res_taken;
      upd_d.fail   = fail;
      upd_d.addr   = head_entry.pc[IDX_LSB +: IDX_W];
      upd_d.target = bus.res_target[IDX_LSB +: IDX_W];
    end
    if (fail) begin
      redirect_pc_d = bus.res_taken ? bus.res_target : (head_entry.pc + DELAY_SLOT_OFFSET);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_q            <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      upd_q            <= upd_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign bus.pred_ready     = ~full;
  assign bus.occupancy      = count;
  assign bus.upd_branch     = upd_q.branch;
  assign bus.upd_res        = upd_q.res;
  assign bus.upd_fail       = upd_q.fail;
  assign bus.upd_addr       = upd_q.addr;
  assign bus.upd_target     = upd_q.target;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVER_PERF_EN
  logic [31:0] perf_branch_cnt_q, perf_branch_cnt_d;
  logic [31:0] perf_miss_cnt_q, perf_miss_cnt_d;

  // Counters follow the registered update strobe, so they lag it by one cycle.
  always_comb begin
    perf_branch_cnt_d = perf_branch_cnt_q + 32'(upd_q.branch);
    perf_miss_cnt_d   = perf_miss_cnt_q + 32'(upd_q.branch & upd_q.fail);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_branch_cnt_q <= '0;
      perf_miss_cnt_q   <= '0;
    end else begin
      perf_branch_cnt_q <= perf_branch_cnt_d;
      perf_miss_cnt_q   <= perf_miss_cnt_d;
    end
  end

  assign bus.perf_branch_cnt = perf_branch_cnt_q;
  assign bus.perf_miss_cnt   = perf_miss_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed test-plan cases plus random
// traffic compared every cycle against a queue-based reference model.
module tb_branch_resolver;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int IDX_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolver_if #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) bus ();

  branch_resolver #(
    .DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W), .IDX_LSB(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic        e_branch = 0, e_res = 0, e_fail = 0, e_rv = 0;
  logic [7:0]  e_addr = 0, e_tgt = 0;
  logic [31:0] e_rpc = 0;
  logic [31:0] m_bcnt = 0, m_mcnt = 0;

  task automatic model_step();
    ent_t h;
    int   old_size;
    logic resolved, miss;
    old_size = mq.size();
    e_branch = 0; e_res = 0; e_fail = 0; e_addr = 0; e_tgt = 0; e_rv = 0;
    if (bus.flush) begin
      mq.delete();
    end else begin
      resolved = bus.res_valid && (old_size > 0);
      miss     = 0;
      if (resolved) begin
        h        = mq[0];
        miss     = (bus.res_taken != h.taken) || (bus.res_taken && bus.res_target != h.tgt);
        e_branch = 1;
        e_res    = bus.res_taken;
        e_fail   = miss;
        e_addr   = h.pc[9:2];
        e_tgt    = bus.res_target[9:2];
        if (miss) begin
          e_rv  = 1;
          e_rpc = bus.res_taken ? bus.res_target : h.pc + 32'd8;
        end
      end
      if (miss) begin
        mq.delete();
      end else begin
        if (resolved) void'(mq.pop_front());
        if (bus.pred_valid && (old_size < DEPTH || resolved))
          mq.push_back('{pc: bus.pred_pc, taken: bus.pred_taken, tgt: bus.pred_target});
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        e_branch = 0; e_res = 0; e_fail = 0; e_addr = 0; e_tgt = 0; e_rv = 0; e_rpc = 0;
        m_bcnt = 0; m_mcnt = 0;
      end else begin
        m_bcnt += {31'd0, e_branch};
        m_mcnt += {31'd0, e_branch & e_fail};
        model_step();
      end
      #1;
      chk("upd_branch", {63'd0, bus.upd_branch}, {63'd0, e_branch});
      chk("upd_res", {63'd0, bus.upd_res}, {63'd0, e_res});
      chk("upd_fail", {63'd0, bus.upd_fail}, {63'd0, e_fail});
      chk("upd_addr", {56'd0, bus.upd_addr}, {56'd0, e_addr});
      chk("upd_target", {56'd0, bus.upd_target}, {56'd0, e_tgt});
      chk("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, e_rv});
      chk("redirect_pc", {32'd0, bus.redirect_pc}, {32'd0, e_rpc});
      chk("occupancy", {61'd0, bus.occupancy}, 64'(mq.size()));
      chk("pred_ready", {63'd0, bus.pred_ready}, {63'd0, mq.size() != DEPTH});
`ifdef BRANCH_RESOLVER_PERF_EN
      chk("perf_branch_cnt", {32'd0, bus.perf_branch_cnt}, {32'd0, m_bcnt});
      chk("perf_miss_cnt", {32'd0, bus.perf_miss_cnt}, {32'd0, m_mcnt});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input logic pv, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptg, input logic rv, input logic rt,
                        input logic [31:0] rtg, input logic fl);
    bus.pred_valid  = pv;
    bus.pred_pc     = pc;
    bus.pred_taken  = pt;
    bus.pred_target = ptg;
    bus.res_valid   = rv;
    bus.res_taken   = rt;
    bus.res_target  = rtg;
    bus.flush       = fl;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] ptg);
    set_in(1, pc, pt, ptg, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    logic        pv, pt, rv, rt, fl;
    logic [31:0] pc, ptg, rtg;

    idle();
    repeat (3) tick();
    chk("rst_upd_branch", {63'd0, bus.upd_branch}, 64'd0);
    chk("rst_redirect_pc", {32'd0, bus.redirect_pc}, 64'd0);
    chk("rst_pred_ready", {63'd0, bus.pred_ready}, 64'd1);
    chk("rst_occupancy", {61'd0, bus.occupancy}, 64'd0);
    rst = 0;
    tick();

    // correct taken prediction
    push(32'h100, 1, 32'h200);
    set_in(0, 0, 0, 0, 1, 1, 32'h200, 0); tick();
    chk("t1_branch", {63'd0, bus.upd_branch}, 64'd1);
    chk("t1_res", {63'd0, bus.upd_res}, 64'd1);
    chk("t1_fail", {63'd0, bus.upd_fail}, 64'd0);
    chk("t1_addr", {56'd0, bus.upd_addr}, 64'h40);
    chk("t1_target", {56'd0, bus.upd_target}, 64'h80);
    chk("t1_redirect", {63'd0, bus.redirect_valid}, 64'd0);
    idle(); tick();
    chk("t1_branch_drop", {63'd0, bus.upd_branch}, 64'd0);

    // predicted not taken, actually taken
    push(32'h100, 0, 32'h0);
    set_in(0, 0, 0, 0, 1, 1, 32'h300, 0); tick();
    chk("t2_fail", {63'd0, bus.upd_fail}, 64'd1);
    chk("t2_redirect", {63'd0, bus.redirect_valid}, 64'd1);
    chk("t2_redirect_pc", {32'd0, bus.redirect_pc}, 64'h300);
    idle(); tick();
    chk("t2_redirect_pulse", {63'd0, bus.redirect_valid}, 64'd0);

    // one more hit: 3 resolves with 1 miss so far
    push(32'h100, 1, 32'h200);
    set_in(0, 0, 0, 0, 1, 1, 32'h200, 0); tick();
    idle(); tick();
`ifdef BRANCH_RESOLVER_PERF_EN
    chk("perf_branch_3", {32'd0, bus.perf_branch_cnt}, 64'd3);
    chk("perf_miss_1", {32'd0, bus.perf_miss_cnt}, 64'd1);
`endif

    // predicted taken, actually not taken: resume after the delay slot
    push(32'h180, 1, 32'h400);
    set_in(0, 0, 0, 0, 1, 0, 32'h0, 0); tick();
    chk("t3_fail", {63'd0, bus.upd_fail}, 64'd1);
    chk("t3_redirect_pc", {32'd0, bus.redirect_pc}, 64'h188);
    idle(); tick();

    // fill, hold a push while full, push alongside a correct resolve
    for (int i = 1; i <= 4; i++) push(32'(i * 16), 1, 32'h1000 + 32'(i * 16));
    chk("t4_full_ready", {63'd0, bus.pred_ready}, 64'd0);
    chk("t4_full_occ", {61'd0, bus.occupancy}, 64'd4);
    set_in(1, 32'h50, 1, 32'h1050, 0, 0, 0, 0); tick();
    chk("t4_held_occ", {61'd0, bus.occupancy}, 64'd4);
    set_in(1, 32'h50, 1, 32'h1050, 1, 1, 32'h1010, 0); tick();
    chk("t4_swap_occ", {61'd0, bus.occupancy}, 64'd4);
    chk("t4_swap_addr", {56'd0, bus.upd_addr}, 64'h04);
    chk("t4_swap_fail", {63'd0, bus.upd_fail}, 64'd0);
    for (int i = 2; i <= 5; i++) begin
      set_in(0, 0, 0, 0, 1, 1, 32'h1000 + 32'(i * 16), 0); tick();
      chk("t4_order_addr", {56'd0, bus.upd_addr}, 64'(i * 4));
      chk("t4_order_fail", {63'd0, bus.upd_fail}, 64'd0);
    end
    chk("t4_drained", {61'd0, bus.occupancy}, 64'd0);

    // mispredict with a same-cycle push squashes everything
    for (int i = 0; i < 3; i++) push(32'h60 + 32'(i * 16), 1, 32'h2000);
    set_in(1, 32'h90, 1, 32'h2000, 1, 1, 32'h2999, 0); tick();
    chk("t5_occ", {61'd0, bus.occupancy}, 64'd0);
    chk("t5_redirect_pc", {32'd0, bus.redirect_pc}, 64'h2999);
    set_in(0, 0, 0, 0, 1, 1, 32'h2000, 0); tick();
    chk("t5_empty_branch", {63'd0, bus.upd_branch}, 64'd0);

    // flush beats resolve and push
    push(32'hA0, 1, 32'h3000);
    push(32'hB0, 1, 32'h3000);
    set_in(1, 32'hC0, 1, 32'h3000, 1, 1, 32'h3000, 1); tick();
    chk("t6_occ", {61'd0, bus.occupancy}, 64'd0);
    chk("t6_branch", {63'd0, bus.upd_branch}, 64'd0);
    chk("t6_redirect", {63'd0, bus.redirect_valid}, 64'd0);

    // redirect registered just before a flush still shows
    push(32'hD0, 0, 32'h0);
    set_in(0, 0, 0, 0, 1, 1, 32'h5000, 0); tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("t7_redirect_kept", {63'd0, bus.redirect_valid}, 64'd1);
    tick();
    idle();

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      pv  = ($urandom_range(0, 99) < 60);
      pc  = $urandom() & 32'hFFFF_FFFC;
      pt  = $urandom_range(0, 1) == 1;
      ptg = ($urandom_range(0, 1) == 1) ? 32'h4000 : 32'h4100;
      rv  = ($urandom_range(0, 99) < 50);
      if (mq.size() > 0 && $urandom_range(0, 99) < 75) begin
        rt  = mq[0].taken;
        rtg = rt ? mq[0].tgt : $urandom();
      end else begin
        rt  = $urandom_range(0, 1) == 1;
        rtg = ($urandom_range(0, 1) == 1) ? 32'h4000 : 32'h4100;
      end
      fl = ($urandom_range(0, 99) < 3);
      set_in(pv, pc, pt, ptg, rv, rt, rtg, fl);
      if (c == 1000) rst = 1;
      if (c == 1002) rst = 0;
      tick();
    end
    idle();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
Name: branch_resolver

Overview:
- Execute-side counterpart of the branch predictor. Queues each prediction issued at fetch and pops it when execute resolves the branch.
- Compares predicted against actual outcome. Drives the predictor update interface (branch / res / fail / addr / target) and a fetch redirect on mispredict.
- Sits between the IF prediction path, the EX branch unit and the predictor.

Parameters:
- DEPTH, 4: in-flight prediction entries; power of two, ≥2.
- PC_W, 32: PC width.
- IDX_W, 8: predictor index width.
- IDX_LSB, 2: lowest PC bit used for the predictor index/target fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pred_valid  in  1  fetch issues a branch prediction
- pred_ready  out  1  queue can accept (= !full)
- pred_pc  in  PC_W  branch PC
- pred_taken  in  1  predicted direction
- pred_target  in  PC_W  predicted target (don't-care when not taken)
- res_valid  in  1  execute resolves the oldest outstanding branch
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual taken target
- flush  in  1  pipeline flush (exception/eret); discards all entries
- upd_branch  out  1  predictor update strobe, one cycle
- upd_res  out  1  actual direction
- upd_fail  out  1  mispredict
- upd_addr  out  IDX_W  pred_pc[IDX_LSB+IDX_W-1:IDX_LSB]
- upd_target  out  IDX_W  res_target[IDX_LSB+IDX_W-1:IDX_LSB]
- redirect_valid  out  1  fetch redirect pulse
- redirect_pc  out  PC_W  correct fetch PC
- occupancy  out  $clog2(DEPTH)+1  entry count

Behaviour:
- Reset (async, rst=1): wr_ptr = rd_ptr = count = 0; all upd_*, redirect_valid and redirect_pc are 0; pred_ready = 1.
- Storage: circular FIFO of {pc, taken, target}. Pointers wrap modulo DEPTH.
- Push: pred_valid & pred_ready → write at wr_ptr, wr_ptr+1.
  - pred_valid while full: ignored, nothing written. The producer must hold the request.
- Resolve: res_valid & count≠0 → pop the head.
  - fail = (res_taken ≠ head.taken) | (res_taken & head.taken & res_target ≠ head.target).
  - res_valid with count=0: ignored, no update, no redirect.
- Outputs are registered; 1-cycle latency from the resolving edge:
  - upd_branch = 1
  - upd_res = res_taken
  - upd_fail = fail
  - upd_addr from head.pc
  - upd_target from res_target
  - All upd_* fields return to 0 the next cycle when no resolve occurs.
- Mispredict (fail=1), same edge:
  - Every entry is cleared (younger entries are wrong-path): count = 0, rd_ptr = wr_ptr.
  - A same-cycle push is discarded.
  - Next cycle: redirect_valid = 1 for exactly one cycle; redirect_pc = res_taken ? res_target : head.pc+8 (skips the delay slot).
- Push and correct resolve in the same cycle: both happen, count unchanged. This is legal even when full.
- flush has top priority:
  - Queue cleared; any same-cycle push and resolve are discarded.
  - No upd_branch and no redirect_valid on the next cycle.
  - A redirect already registered the previous cycle still appears.
- pred_ready = (count ≠ DEPTH), combinational from count.
- Reset asserted mid-operation clears state immediately. Outstanding updates are lost.

Optional Feature:
- Macro: BRANCH_RESOLVER_PERF_EN.
- Defined:
  - Adds outputs perf_branch_cnt[31:0] and perf_miss_cnt[31:0].
  - Each increments on every registered upd_branch, and on upd_branch & upd_fail respectively.
  - Both reset to 0 and wrap at 2^32.
- Not defined: the ports and counters are absent. Functional behaviour is identical either way.

Decomposition:
- Shared package bp_pkg:
  - constants IDX_W, IDX_LSB, DELAY_SLOT_OFFSET = 8
  - typedef bp_entry_t {pc, taken, target}
  - typedef bp_update_t {branch, res, fail, addr, target}
- One sub-module: bp_fifo, a generic DEPTH-entry FIFO with push/pop/clear.
- Comparison, redirect and update registers stay in branch_resolver.

Test Plan:
- Push pc=0x100 taken, target=0x200; resolve taken, target 0x200 → next cycle upd_branch=1, upd_res=1, upd_fail=0, upd_addr=0x40, upd_target=0x80, no redirect.
- Push pc=0x100 not taken; resolve taken, target 0x300 → upd_fail=1, redirect_valid=1 for one cycle, redirect_pc=0x300.
- Push pc=0x180 taken; resolve not taken → upd_fail=1, redirect_pc=0x188.
- Push 4 entries → pred_ready=0, occupancy=4.
  - 5th push held → nothing written.
  - Push plus correct resolve in the same cycle → occupancy stays 4, FIFO order preserved.
- 3 entries, resolve oldest as a mispredict while pushing → occupancy=0 next cycle, pushed entry absent.
  - Later res_valid with empty queue → no upd_branch.
- flush together with res_valid and pred_valid → occupancy=0, no upd_branch, no redirect.
  - With BRANCH_RESOLVER_PERF_EN defined: after 3 resolves with 1 miss, perf_branch_cnt=3 and perf_miss_cnt=1.
